// File: rtl/dcpu_sysbus.sv
// rtl/dcpu_sysbus.sv - dcpu bus responder: RAM, interval timer, interrupt controller, UART TX
//
// Purpose: answers the dcpu core bus with zero-wait-state RAM plus a peripheral
// window at 0xFF00-0xFF0F (timer, interrupt status/mask, 8N1 UART transmitter).
//
// Ports:
//   i_clk    clock, all state on posedge
//   i_reset  synchronous active-high reset
//   i_addr   byte address from the core (bit 0 ignored)
//   i_dat    write data from the core
//   o_dat    combinational read data to the core
//   i_rw     1 = read, 0 = write (commits on posedge)
//   o_int    registered interrupt request
//   o_tx     UART serial output, idle high
module dcpu_sysbus #(
  parameter int RAM_AW       = 15,
  parameter int CLKS_PER_BIT = 434
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [15:0] i_addr,
  input  logic [15:0] i_dat,
  output logic [15:0] o_dat,
  input  logic        i_rw,
  output logic        o_int,
  output logic        o_tx
);

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {U_IDLE, U_START, U_DATA, U_STOP} uart_state_e;

  // Address decode
  logic       per_sel;
  logic [2:0] reg_sel;
  logic       per_wr;
  logic       we_trld, we_tctrl, we_istat, we_imask, we_utx;
  logic       unused_addr0;

  assign per_sel      = (i_addr[15:4] == 12'hFF0);
  assign reg_sel      = i_addr[3:1];
  assign per_wr       = !i_rw && per_sel;
  assign we_trld      = per_wr && (reg_sel == 3'd1);
  assign we_tctrl     = per_wr && (reg_sel == 3'd2);
  assign we_istat     = per_wr && (reg_sel == 3'd3);
  assign we_imask     = per_wr && (reg_sel == 3'd4);
  assign we_utx       = per_wr && (reg_sel == 3'd5);
  assign unused_addr0 = i_addr[0];

  // RAM: not reset, and writes commit even while i_reset is asserted
  logic [15:0] ram [2**RAM_AW];

  always_ff @(posedge i_clk) begin
    if (!i_rw && !per_sel) begin
      ram[i_addr[RAM_AW:1]] <= i_dat;
    end
  end

  // State registers
  logic [15:0]     tcnt_q, tcnt_d;
  logic [15:0]     trld_q, trld_d;
  logic            ten_q, ten_d;
  logic [1:0]      istat_q, istat_d;
  logic [1:0]      imask_q, imask_d;
  logic            int_q, int_d;
  uart_state_e     ustate_q, ustate_d;
  logic [CW-1:0]   ucnt_q, ucnt_d;
  logic [2:0]      ubit_q, ubit_d;
  logic [7:0]      udata_q, udata_d;
  logic            tx_q, tx_d;
  logic            tmr_hit;
  logic            uart_done;

  // Timer and interrupt controller
  always_comb begin
    tcnt_d  = tcnt_q;
    trld_d  = trld_q;
    ten_d   = ten_q;
    istat_d = istat_q;
    imask_d = imask_q;
    tmr_hit = 1'b0;

    if (ten_q) begin
      if (tcnt_q == 16'd0) begin
        tcnt_d  = trld_q;
        tmr_hit = 1'b1;
      end else begin
        tcnt_d = tcnt_q - 16'd1;
      end
    end

    // A reload write wins over both the decrement and the automatic reload
    if (we_trld) begin
      trld_d = i_dat;
      tcnt_d = i_dat;
    end
    if (we_tctrl) ten_d   = i_dat[0];
    if (we_imask) imask_d = i_dat[1:0];
    if (we_istat) istat_d = istat_q & ~i_dat[1:0];

    // Hardware sets are applied after the W1C so a coincident set survives
    istat_d = istat_d | {uart_done, tmr_hit};
    int_d   = |(istat_q & imask_q);
  end

  // UART transmitter
  always_comb begin
    ustate_d  = ustate_q;
    ucnt_d    = ucnt_q;
    ubit_d    = ubit_q;
    udata_d   = udata_q;
    uart_done = 1'b0;

    case (ustate_q)
      U_IDLE: begin
        if (we_utx) begin
          ustate_d = U_START;
          udata_d  = i_dat[7:0];
          ucnt_d   = '0;
        end
      end
      U_START: begin
        if (ucnt_q == CNT_LAST) begin
          ucnt_d   = '0;
          ubit_d   = 3'd0;
          ustate_d = U_DATA;
        end else begin
          ucnt_d = ucnt_q + CW'(1);
        end
      end
      U_DATA: begin
        if (ucnt_q == CNT_LAST) begin
          ucnt_d = '0;
          if (ubit_q == 3'd7) begin
            ustate_d = U_STOP;
          end else begin
            ubit_d = ubit_q + 3'd1;
          end
        end else begin
          ucnt_d = ucnt_q + CW'(1);
        end
      end
      U_STOP: begin
        if (ucnt_q == CNT_LAST) begin
          ucnt_d    = '0;
          ustate_d  = U_IDLE;
          uart_done = 1'b1;
        end else begin
          ucnt_d = ucnt_q + CW'(1);
        end
      end
      default: ustate_d = U_IDLE;
    endcase

    // o_tx is registered from the next state so the pin lines up with the state
    tx_d = 1'b1;
    if (ustate_d == U_START) begin
      tx_d = 1'b0;
    end else if (ustate_d == U_DATA) begin
      tx_d = udata_d[ubit_d];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      tcnt_q   <= '0;
      trld_q   <= '0;
      ten_q    <= 1'b0;
      istat_q  <= '0;
      imask_q  <= '0;
      int_q    <= 1'b0;
      ustate_q <= U_IDLE;
      ucnt_q   <= '0;
      ubit_q   <= '0;
      udata_q  <= '0;
      tx_q     <= 1'b1;
    end else begin
      tcnt_q   <= tcnt_d;
      trld_q   <= trld_d;
      ten_q    <= ten_d;
      istat_q  <= istat_d;
      imask_q  <= imask_d;
      int_q    <= int_d;
      ustate_q <= ustate_d;
      ucnt_q   <= ucnt_d;
      ubit_q   <= ubit_d;
      udata_q  <= udata_d;
      tx_q     <= tx_d;
    end
  end

  // Read mux
  logic [15:0] per_rdata;

  always_comb begin
    per_rdata = 16'h0000;
    case (reg_sel)
      3'd0:    per_rdata = tcnt_q;
      3'd1:    per_rdata = trld_q;
      3'd2:    per_rdata = {15'd0, ten_q};
      3'd3:    per_rdata = {14'd0, istat_q};
      3'd4:    per_rdata = {14'd0, imask_q};
      3'd6:    per_rdata = {15'd0, (ustate_q != U_IDLE)};
      default: per_rdata = 16'h0000;
    endcase
  end

  assign o_dat = per_sel ? per_rdata : ram[i_addr[RAM_AW:1]];
  assign o_int = int_q;
  assign o_tx  = tx_q;

endmodule

// File: tb/tb_dcpu_sysbus.sv
// tb/tb_dcpu_sysbus.sv - self-checking bench for dcpu_sysbus
module tb_dcpu_sysbus;

  localparam int CPB = 4;

  localparam logic [15:0] A_TCNT  = 16'hFF00;
  localparam logic [15:0] A_TRLD  = 16'hFF02;
  localparam logic [15:0] A_TCTRL = 16'hFF04;
  localparam logic [15:0] A_ISTAT = 16'hFF06;
  localparam logic [15:0] A_IMASK = 16'hFF08;
  localparam logic [15:0] A_UTX   = 16'hFF0A;
  localparam logic [15:0] A_USTAT = 16'hFF0C;
  localparam logic [15:0] A_RSVD  = 16'hFF0E;

  logic        clk;
  logic        rst;
  logic [15:0] addr;
  logic [15:0] wdat;
  logic [15:0] rdat;
  logic        rw;
  logic        irq;
  logic        tx;

  int n_cmp = 0;
  int n_err = 0;

  string       tag_q[$];
  logic [15:0] exp_q[$];

  dcpu_sysbus #(.RAM_AW(15), .CLKS_PER_BIT(CPB)) dut (
    .i_clk  (clk),
    .i_reset(rst),
    .i_addr (addr),
    .i_dat  (wdat),
    .o_dat  (rdat),
    .i_rw   (rw),
    .o_int  (irq),
    .o_tx   (tx)
  );

  initial begin
    clk = 1'b0;
    forever #20 clk = ~clk;
  end

  task automatic push(input string t, input logic [15:0] v);
    tag_q.push_back(t);
    exp_q.push_back(v);
  endtask

  task automatic chk(input logic [15:0] obs);
    string       t;
    logic [15:0] e;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_err++;
      $error("FAIL scoreboard_empty: observed %h expected <none>", obs);
    end else begin
      t = tag_q.pop_front();
      e = exp_q.pop_front();
      assert (obs === e) else begin
        n_err++;
        $error("FAIL %s: observed %h expected %h", t, obs, e);
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    addr = a;
    wdat = d;
    rw   = 1'b0;
    @(negedge clk);
    rw   = 1'b1;
  endtask

  task automatic rd_chk(input string t, input logic [15:0] a, input logic [15:0] e);
    push(t, e);
    addr = a;
    rw   = 1'b1;
    #1;
    chk(rdat);
  endtask

  task automatic sig_chk(input string t, input logic obs, input logic e);
    push(t, {15'd0, e});
    chk({15'd0, obs});
  endtask

  // 8N1 frame model: c counts cycles from the cycle after the UTX write
  function automatic logic frame_bit(input logic [7:0] b, input int c);
    int k;
    k = c / CPB;
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
    return 1'b1;
  endfunction

  task automatic push_frame(input string t, input logic [7:0] b);
    for (int c = 0; c < 10 * CPB; c++) begin
      push({t, "_tx"}, {15'd0, frame_bit(b, c)});
      push({t, "_busy"}, 16'h0001);
    end
  endtask

  initial begin
    rst  = 1'b1;
    rw   = 1'b1;
    addr = 16'h0000;
    wdat = 16'h0000;
    repeat (3) tick();

    // Reset state
    sig_chk("rst_tx", tx, 1'b1);
    sig_chk("rst_int", irq, 1'b0);
    rd_chk("rst_tcnt", A_TCNT, 16'h0000);
    rd_chk("rst_ustat", A_USTAT, 16'h0000);
    rst = 1'b0;
    tick();

    // RAM, mirrored byte lane, vector location
    wr(16'h0200, 16'h1234);
    rd_chk("ram_0200", 16'h0200, 16'h1234);
    rd_chk("ram_0201", 16'h0201, 16'h1234);
    wr(16'hFFFA, 16'hBEEF);
    rd_chk("ram_fffa", 16'hFFFA, 16'hBEEF);
    rd_chk("ram_0200_keep", 16'h0200, 16'h1234);
    rd_chk("rsvd_reads0", A_RSVD, 16'h0000);

    // Timer: reload 3, expiry 4 cycles after enable
    wr(A_IMASK, 16'h0001);
    wr(A_TRLD, 16'h0003);
    rd_chk("tcnt_loaded", A_TCNT, 16'h0003);
    wr(A_TCTRL, 16'h0001);
    rd_chk("tctrl", A_TCTRL, 16'h0001);
    repeat (3) tick();
    rd_chk("istat_e3", A_ISTAT, 16'h0000);
    rd_chk("tcnt_e3", A_TCNT, 16'h0000);
    tick();
    rd_chk("istat_e4", A_ISTAT, 16'h0001);
    rd_chk("tcnt_reload", A_TCNT, 16'h0003);
    sig_chk("int_e4", irq, 1'b0);
    tick();
    sig_chk("int_e5", irq, 1'b1);
    rd_chk("tcnt_e5", A_TCNT, 16'h0002);

    // W1C: o_int drops one cycle after the clear lands
    wr(A_ISTAT, 16'h0001);
    rd_chk("istat_cleared", A_ISTAT, 16'h0000);
    sig_chk("int_lag", irq, 1'b1);
    tick();
    sig_chk("int_dropped", irq, 1'b0);
    rd_chk("tcnt_e7", A_TCNT, 16'h0000);
    // Clear coincides with the next expiry: the set wins
    wr(A_ISTAT, 16'h0001);
    rd_chk("istat_set_wins", A_ISTAT, 16'h0001);
    wr(A_TCTRL, 16'h0000);
    wr(A_ISTAT, 16'h0003);
    rd_chk("istat_clr_all", A_ISTAT, 16'h0000);

    // UART frame 0xA5
    rd_chk("utx_reads0", A_UTX, 16'h0000);
    wr(A_UTX, 16'h00A5);
    push_frame("a5", 8'hA5);
    for (int c = 0; c < 10 * CPB; c++) begin
      chk({15'd0, tx});
      addr = A_USTAT;
      #1;
      chk(rdat);
      tick();
    end
    sig_chk("a5_idle_tx", tx, 1'b1);
    rd_chk("a5_not_busy", A_USTAT, 16'h0000);
    rd_chk("a5_done", A_ISTAT, 16'h0002);

    // UTX write while busy is ignored
    wr(A_ISTAT, 16'h0002);
    wr(A_UTX, 16'h003C);
    push_frame("3c", 8'h3C);
    for (int c = 0; c < 10 * CPB; c++) begin
      chk({15'd0, tx});
      addr = A_USTAT;
      #1;
      chk(rdat);
      if (c == 5) wr(A_UTX, 16'h00FF);
      else tick();
    end
    sig_chk("3c_idle_tx", tx, 1'b1);
    rd_chk("3c_done", A_ISTAT, 16'h0002);

    // Reset mid-frame and mid-count
    wr(A_IMASK, 16'h0003);
    wr(A_TRLD, 16'h0005);
    wr(A_TCTRL, 16'h0001);
    wr(A_UTX, 16'h0000);
    repeat (3) tick();
    sig_chk("pre_rst_tx", tx, 1'b0);
    sig_chk("pre_rst_int", irq, 1'b1);
    rd_chk("pre_rst_tcnt", A_TCNT, 16'h0001);
    rst  = 1'b1;
    addr = 16'h0300;
    wdat = 16'h5A5A;
    rw   = 1'b0;
    tick();
    sig_chk("rst_mid_tx", tx, 1'b1);
    sig_chk("rst_mid_int", irq, 1'b0);
    addr = A_TRLD;
    wdat = 16'h0007;
    tick();
    rw  = 1'b1;
    rst = 1'b0;
    rd_chk("post_tcnt", A_TCNT, 16'h0000);
    rd_chk("post_trld", A_TRLD, 16'h0000);
    rd_chk("post_tctrl", A_TCTRL, 16'h0000);
    rd_chk("post_istat", A_ISTAT, 16'h0000);
    rd_chk("post_imask", A_IMASK, 16'h0000);
    rd_chk("post_ustat", A_USTAT, 16'h0000);
    rd_chk("ram_during_rst", 16'h0300, 16'h5A5A);
    tick();
    sig_chk("post_tx", tx, 1'b1);
    sig_chk("post_int", irq, 1'b0);
    rd_chk("post_tcnt_hold", A_TCNT, 16'h0000);

    if (exp_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $error("FAIL scoreboard_leftover: observed %0d pending expected 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
